// File: rtl/dma_engine_if.sv
// -----------------------------------------------------------------------------
// dma_engine_if
// Groups the command, status and SRAM-arbiter signals of the DMA copy engine.
//   Command : cmd_valid, cmd_ready, cmd_src, cmd_dst, cmd_len
//   Status  : busy, remaining, done
//   SRAM    : mem_req, mem_gnt, mem_addr, mem_we, mem_di, mem_do
// Modports:
//   master - the DMA engine (drives ready/status and the SRAM request side)
//   slave  - the environment (command source, arbiter and SRAM)
// -----------------------------------------------------------------------------
interface dma_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_src;
  logic [15:0] cmd_dst;
  logic [15:0] cmd_len;
  logic        busy;
  logic [15:0] remaining;
  logic        done;
  logic        mem_req;
  logic        mem_gnt;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_di;
  logic [31:0] mem_do;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, mem_gnt, mem_do,
    output cmd_ready, busy, remaining, done, mem_req, mem_addr, mem_we, mem_di
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_len, mem_gnt, mem_do,
    input  cmd_ready, busy, remaining, done, mem_req, mem_addr, mem_we, mem_di
  );
endinterface

// File: rtl/dma_engine.sv
// -----------------------------------------------------------------------------
// dma_engine
// Single-channel word copy engine sharing one SRAM through an arbiter.
// Each word is read (RD), its data captured one cycle later (RDW) and then
// written (WR); with the grant held high a word takes three cycles.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset; abandons any transfer
//   bus    - dma_engine_if.master: command handshake, busy/remaining/done
//            status and the SRAM request/grant/address/data signals
// Optional feature (macro DMA_OVERLAP_EN): when the destination starts inside
// the source block (src < dst < src + len, no wrap) the copy runs from the
// top word downwards so source words are read before being overwritten.
// Without the macro the copy is always ascending.
// -----------------------------------------------------------------------------
module dma_engine (
  input  logic         clk,
  input  logic         reset,
  dma_engine_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, RDW, WR} state_t;

  state_t      state, state_nxt;
  logic [15:0] src_addr, dst_addr, rem;
  logic [31:0] data;
  logic        done_r;
  logic        desc;
  logic        accept, wr_fire, last_word;
  logic        overlap;
  logic [15:0] start_src, start_dst, step;

  assign accept    = bus.cmd_valid && (state == IDLE);
  assign wr_fire   = (state == WR) && bus.mem_gnt;
  assign last_word = (rem == 16'd1);

`ifdef DMA_OVERLAP_EN
  // 17-bit end address so the overlap test never wraps.
  logic [16:0] src_end;
  assign src_end = {1'b0, bus.cmd_src} + {1'b0, bus.cmd_len};
  assign overlap = (bus.cmd_src < bus.cmd_dst) && ({1'b0, bus.cmd_dst} < src_end);
`else
  assign overlap = 1'b0;
`endif

  // Descending copies start at the last word of each block.
  assign start_src = overlap ? bus.cmd_src + bus.cmd_len - 16'd1 : bus.cmd_src;
  assign start_dst = overlap ? bus.cmd_dst + bus.cmd_len - 16'd1 : bus.cmd_dst;
  assign step      = desc ? 16'hFFFF : 16'h0001;

  assign bus.remaining = rem;
  assign bus.done      = done_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 16'd0;
    bus.mem_di    = 32'd0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        // A zero-length command is accepted but never leaves IDLE.
        if (bus.cmd_valid && (bus.cmd_len != 16'd0)) state_nxt = RD;
      end
      RD: begin
        bus.busy     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = src_addr;
        if (bus.mem_gnt) state_nxt = RDW;
      end
      RDW: begin
        bus.busy  = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        bus.busy     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = dst_addr;
        bus.mem_di   = data;
        if (bus.mem_gnt) state_nxt = last_word ? IDLE : RD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_addr <= 16'd0;
      dst_addr <= 16'd0;
      rem      <= 16'd0;
      data     <= 32'd0;
      done_r   <= 1'b0;
      desc     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        src_addr <= start_src;
        dst_addr <= start_dst;
        rem      <= bus.cmd_len;
        desc     <= overlap;
        if (bus.cmd_len == 16'd0) done_r <= 1'b1;
      end
      // SRAM read data arrives one cycle after the granted read.
      if (state == RDW) data <= bus.mem_do;
      if (wr_fire) begin
        rem      <= rem - 16'd1;
        src_addr <= src_addr + step;
        dst_addr <= dst_addr + step;
        if (last_word) done_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
`timescale 1ns/1ps
module tb_dma_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dma_engine_if bus();

  dma_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int passes = 0;

  logic [31:0] mem     [0:65535];  // SRAM seen by the DUT
  logic [31:0] ref_mem [0:65535];  // reference model memory

  wr_t         exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  int          exp_done_q[$];
  logic [15:0] exp_rem = 16'd0;

  int done_cnt = 0, busy_cycles = 0, req_cycles = 0;
  int rd_stall = 0, wr_stall = 0;
  bit rand_gnt = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_word(input logic [15:0] a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Reference model: copy word by word in the order the rules dictate and
  // record the expected reads, writes and completion.
  task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input int hold);
    bit down;
    int i;
    logic [15:0] sa, da;
    down = 1'b0;
`ifdef DMA_OVERLAP_EN
    down = (int'(s) < int'(d)) && (int'(d) < int'(s) + int'(l));
`endif
    for (int k = 0; k < int'(l); k++) begin
      i  = down ? int'(l) - 1 - k : k;
      sa = s + 16'(i);
      da = d + 16'(i);
      ref_mem[da] = ref_mem[sa];
      exp_rd_q.push_back(sa);
      exp_wr_q.push_back('{addr: da, data: ref_mem[da]});
    end
    exp_done_q.push_back(int'(l));
    check("cmd_ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_src   = s;
    bus.cmd_dst   = d;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    tick(1);
    if (hold > 0) begin
      // Junk commands presented while busy must be ignored.
      bus.cmd_src = 16'($urandom);
      bus.cmd_dst = 16'($urandom);
      bus.cmd_len = 16'($urandom_range(1, 9));
      tick(hold);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick(1);
      n++;
    end
    check("done_within_budget", 64'(done_cnt != start), 64'd1);
  endtask

  task automatic run(input string name, input logic [15:0] s, input logic [15:0] d,
                     input logic [15:0] l, input int hold, input int exp_busy);
    int d0;
    logic [15:0] a;
    d0 = done_cnt;
    busy_cycles = 0;
    issue(s, d, l, hold);
    wait_done(400);
    tick(2);
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    if (exp_busy >= 0) check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
    check({name, "_writes_left"}, 64'(exp_wr_q.size()), 64'd0);
    check({name, "_reads_left"}, 64'(exp_rd_q.size()), 64'd0);
    for (int k = 0; k < int'(l); k++) begin
      a = d + 16'(k);
      check({name, "_dst_word"}, 64'(mem[a]), 64'(ref_mem[a]));
    end
  endtask

  // SRAM / arbiter responder and scoreboard monitor.  Runs on the falling
  // edge, when all DUT outputs and bench inputs are stable, and predicts
  // what the next rising edge will do.
  initial begin : monitor
    bit          pend_rd;
    logic [15:0] pend_addr;
    bit          in_req;
    int          wait_cnt, limit;
    logic [15:0] h_addr;
    logic        h_we;
    logic [31:0] h_di;
    wr_t         w;
    logic [15:0] ra;
    pend_rd = 1'b0;
    pend_addr = 16'd0;
    in_req = 1'b0;
    wait_cnt = 0;
    limit = 0;
    bus.mem_gnt = 1'b0;
    bus.mem_do  = 32'd0;
    forever begin
      @(negedge clk);
      bus.mem_do  = pend_rd ? mem[pend_addr] : $urandom;
      pend_rd     = 1'b0;
      bus.mem_gnt = 1'b0;
      if (reset) begin
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_mem_req", 64'(bus.mem_req), 64'd0);
        check("reset_remaining", 64'(bus.remaining), 64'd0);
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_done_q.delete();
        exp_rem = 16'd0;
        in_req = 1'b0;
      end else begin
        check("remaining", 64'(bus.remaining), 64'(exp_rem));
        check("ready_is_not_busy", 64'(bus.cmd_ready), 64'(!bus.busy));
        if (!bus.busy) check("no_req_when_idle", 64'(bus.mem_req), 64'd0);
        if (!bus.mem_req)
          check("bus_zero_without_req", 64'({bus.mem_we, bus.mem_addr, bus.mem_di}), 64'd0);
        if (bus.busy) busy_cycles++;
        if (bus.done) begin
          done_cnt++;
          check("done_expected", 64'(exp_done_q.size() > 0), 64'd1);
          if (exp_done_q.size() > 0) void'(exp_done_q.pop_front());
          check("done_after_last_write", 64'(exp_wr_q.size()), 64'd0);
        end
        if (bus.mem_req) begin
          req_cycles++;
          if (in_req) begin
            check("stall_addr_stable", 64'(bus.mem_addr), 64'(h_addr));
            check("stall_we_stable", 64'(bus.mem_we), 64'(h_we));
            check("stall_di_stable", 64'(bus.mem_di), 64'(h_di));
          end else begin
            in_req   = 1'b1;
            wait_cnt = 0;
            h_addr   = bus.mem_addr;
            h_we     = bus.mem_we;
            h_di     = bus.mem_di;
            limit    = rand_gnt ? int'($urandom_range(0, 3)) : (bus.mem_we ? wr_stall : rd_stall);
          end
          if (wait_cnt >= limit) begin
            bus.mem_gnt = 1'b1;
            in_req = 1'b0;
            if (bus.mem_we) begin
              check("write_expected", 64'(exp_wr_q.size() > 0), 64'd1);
              if (exp_wr_q.size() > 0) begin
                w = exp_wr_q.pop_front();
                check("write_addr", 64'(bus.mem_addr), 64'(w.addr));
                check("write_data", 64'(bus.mem_di), 64'(w.data));
              end
              mem[bus.mem_addr] = bus.mem_di;
              exp_rem = exp_rem - 16'd1;
            end else begin
              check("read_expected", 64'(exp_rd_q.size() > 0), 64'd1);
              if (exp_rd_q.size() > 0) begin
                ra = exp_rd_q.pop_front();
                check("read_addr", 64'(bus.mem_addr), 64'(ra));
              end
              pend_rd   = 1'b1;
              pend_addr = bus.mem_addr;
            end
          end else begin
            wait_cnt++;
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) exp_rem = bus.cmd_len;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    logic [31:0] v0, v1, old1;
    int n, r0, d0;
    logic [15:0] s, d, l;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = 16'd0;
    bus.cmd_dst   = 16'd0;
    bus.cmd_len   = 16'd0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    // Reset state
    tick(2);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_remaining", 64'(bus.remaining), 64'd0);
    check("rst_mem_bus", 64'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_di}), 64'd0);
    reset = 1'b0;
    tick(2);

    // Basic three-word copy with junk commands presented while busy
    set_word(16'h0010, 32'hAAAA_0001);
    set_word(16'h0011, 32'hBBBB_0002);
    set_word(16'h0012, 32'hCCCC_0003);
    run("copy3", 16'h0010, 16'h0020, 16'd3, 4, 9);
    check("copy3_w0", 64'(mem[16'h0020]), 64'h0000_0000_AAAA_0001);
    check("copy3_w1", 64'(mem[16'h0021]), 64'h0000_0000_BBBB_0002);
    check("copy3_w2", 64'(mem[16'h0022]), 64'h0000_0000_CCCC_0003);

    // Zero-length command
    r0 = req_cycles;
    run("len0", 16'h0040, 16'h0050, 16'd0, 0, 0);
    check("len0_no_mem_req", 64'(req_cycles - r0), 64'd0);
    check("len0_remaining", 64'(bus.remaining), 64'd0);

    // Arbiter stalls: 4 cycles in RD, 2 in WR
    rd_stall = 4;
    wr_stall = 2;
    run("stall", 16'h0100, 16'h0180, 16'd1, 0, 9);
    rd_stall = 0;
    wr_stall = 0;

    // Address wrap
    v0 = mem[16'hFFFF];
    v1 = mem[16'h0000];
    run("wrap", 16'hFFFF, 16'h0100, 16'd2, 0, 6);
    check("wrap_w0", 64'(mem[16'h0100]), 64'(v0));
    check("wrap_w1", 64'(mem[16'h0101]), 64'(v1));

    // Reset while writing word 2 of 4
    old1 = mem[16'h0301];
    d0 = done_cnt;
    issue(16'h0200, 16'h0300, 16'd4, 0);
    n = 0;
    while (!(bus.mem_we && bus.remaining == 16'd3) && n < 100) begin
      tick(1);
      n++;
    end
    check("reached_word2_wr", 64'(bus.mem_we && bus.remaining == 16'd3), 64'd1);
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_ready", 64'(bus.cmd_ready), 64'd1);
    check("async_rst_remaining", 64'(bus.remaining), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_mem_bus", 64'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_di}), 64'd0);
    tick(1);
    reset = 1'b0;
    tick(2);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_word1_written", 64'(mem[16'h0300]), 64'(mem[16'h0200]));
    check("abort_word2_untouched", 64'(mem[16'h0301]), 64'(old1));
    for (int k = 1; k < 4; k++) ref_mem[16'h0300 + 16'(k)] = mem[16'h0300 + 16'(k)];
    run("after_reset", 16'h0400, 16'h0480, 16'd3, 0, 9);

    // Overlapping blocks, destination above source
    set_word(16'h0010, 32'd1);
    set_word(16'h0011, 32'd2);
    set_word(16'h0012, 32'd3);
    set_word(16'h0013, 32'd4);
    run("overlap", 16'h0010, 16'h0012, 16'd4, 0, 12);
`ifdef DMA_OVERLAP_EN
    check("overlap_w0", 64'(mem[16'h0012]), 64'd1);
    check("overlap_w1", 64'(mem[16'h0013]), 64'd2);
    check("overlap_w2", 64'(mem[16'h0014]), 64'd3);
    check("overlap_w3", 64'(mem[16'h0015]), 64'd4);
`else
    check("overlap_w0", 64'(mem[16'h0012]), 64'd1);
    check("overlap_w1", 64'(mem[16'h0013]), 64'd2);
    check("overlap_w2", 64'(mem[16'h0014]), 64'd1);
    check("overlap_w3", 64'(mem[16'h0015]), 64'd2);
`endif

    // Randomized commands with a randomly stalling arbiter
    rand_gnt = 1'b1;
    for (int t = 0; t < 10; t++) begin
      s = 16'($urandom);
      l = 16'($urandom_range(0, 6));
      d = s + 16'd32 + 16'($urandom_range(0, 200));
      run("random", s, d, l, 0, -1);
    end
    rand_gnt = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with ports `clk` (input, 1 bit, rising-edge clock) and `reset` (input, 1 bit, asynchronous active-high reset).
REQ-002 SHALL have command port `cmd_valid` (input, 1 bit): a CPY command is presented.
REQ-003 SHALL have `cmd_ready` (output, 1 bit): the engine can accept a command.
REQ-004 SHALL have `cmd_src`, `cmd_dst`, `cmd_len` (inputs, 16 bits each): source word address, destination word address, word count.
REQ-005 SHALL have `busy` (output, 1 bit): a transfer is in progress.
REQ-006 SHALL have `remaining` (output, 16 bits): words not yet written; this is the value read by POL.
REQ-007 SHALL have `done` (output, 1 bit): one-cycle pulse when a transfer completes.
REQ-008 SHALL have `mem_req` (output, 1 bit): SRAM access request to the arbiter.
REQ-009 SHALL have `mem_gnt` (input, 1 bit): the arbiter grants this cycle's access.
REQ-010 SHALL have `mem_addr` (output, 16 bits), `mem_we` (output, 1 bit), `mem_di` (output, 32 bits) and `mem_do` (input, 32 bits): SRAM address, write enable, write data and read data.

Function
REQ-011 SHALL implement the states IDLE, RD, RDW and WR.
REQ-012 SHALL drive `cmd_ready` = 1 only in IDLE, and `busy` = 1 in any state other than IDLE.
REQ-013 SHALL accept a command on a rising edge where `cmd_valid` & `cmd_ready`; it latches src, dst and len, and sets `remaining` = len.
REQ-014 SHALL, for an accepted command with len = 0, stay in IDLE, make no memory access and pulse `done` on the next cycle.
REQ-015 SHALL, for an accepted command with len > 0, go IDLE -> RD.
REQ-016 SHALL, in RD, drive `mem_req` = 1, `mem_we` = 0, `mem_addr` = current src, and move to RDW on the edge where `mem_gnt` = 1; otherwise it holds in RD.
REQ-017 SHALL, in RDW, drive `mem_req` = 0, capture `mem_do` into a 32-bit data register at the end of the cycle (SRAM read latency is 1 cycle), then go to WR.
REQ-018 SHALL, in WR, drive `mem_req` = 1, `mem_we` = 1, `mem_addr` = current dst, `mem_di` = data register, and hold until `mem_gnt` = 1.
REQ-019 SHALL, on a granted WR edge, decrement `remaining`, step src and dst by 1 each (ascending direction), and go to RD if the new `remaining` != 0; otherwise go to IDLE and assert `done` for the following cycle.
REQ-020 SHALL compute all addresses modulo 2^16 (0xFFFF + 1 = 0x0000).
REQ-021 SHALL give a best-case latency, with `mem_gnt` held at 1, of 3 cycles per word; `busy` is high for 3·len cycles.
REQ-022 SHALL drive `mem_req`, `mem_we`, `mem_addr` and `mem_di` to 0 whenever not in RD or WR.
REQ-023 SHALL ignore `cmd_valid` while `busy`; no command is queued.
REQ-024 SHALL keep `mem_addr`, `mem_we` and `mem_di` stable while `mem_req` = 1 and `mem_gnt` = 0.

Reset
REQ-025 SHALL, on assertion of `reset` at any time including mid-transfer, immediately force state IDLE, `remaining` = 0, `done` = 0, `busy` = 0, `cmd_ready` = 1, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_di` = 0, and clear the data register; a partially written block is abandoned.

Configuration
REQ-026 SHALL, when macro DMA_OVERLAP_EN is defined and an accepted command has src < dst < src + len (unsigned, no wrap), copy in descending order: start at src + len − 1 and dst + len − 1, and decrement both addresses on each granted WR.
REQ-027 SHALL, without DMA_OVERLAP_EN, always copy in ascending order; results for overlapping regions with dst > src are then undefined-by-design (source is overwritten before it is read).

Verification
REQ-028 SHALL cover: mem[0x10..0x12] = A, B, C; command src = 0x10, dst = 0x20, len = 3; `mem_gnt` = 1 -> mem[0x20..0x22] = A, B, C; `busy` high 9 cycles; `remaining` 3 -> 2 -> 1 -> 0; one `done` pulse.
REQ-029 SHALL cover: command len = 0 -> no `mem_req`; `done` pulses once; `remaining` = 0.
REQ-030 SHALL cover: `mem_gnt` low for 4 cycles in RD and 2 cycles in WR, len = 1 -> address and data held stable; copy correct; `busy` 9 cycles.
REQ-031 SHALL cover: src = 0xFFFF, dst = 0x0100, len = 2 -> reads 0xFFFF then 0x0000; writes 0x0100 and 0x0101.
REQ-032 SHALL cover: `reset` asserted in WR of word 2 of 4 -> outputs cleared asynchronously; next command accepted normally.
REQ-033 SHALL cover: with DMA_OVERLAP_EN, mem[0x10..0x13] = 1, 2, 3, 4; src = 0x10, dst = 0x12, len = 4 -> mem[0x12..0x15] = 1, 2, 3, 4. Without the macro, the same stimulus gives mem[0x12..0x15] = 1, 2, 1, 2.
